// File: rtl/beta_bypass_pipe.sv
// Bypass/interlock unit for the Beta pipeline: tracks destination tags through
// NSTAGES stages and forwards or stalls per read port. Optional stats: BETA_BYPASS_STATS_EN.
module beta_bypass_pipe #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int NSTAGES  = 3,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 31,
    localparam int SW      = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [AWIDTH-1:0]         id_rc,
    input  logic [SW-1:0]             id_ready_stage,
    input  logic                      flush,
    input  logic [NREAD*AWIDTH-1:0]   ra_addr,
    input  logic [NREAD*DWIDTH-1:0]   rf_data,
    input  logic [NSTAGES*DWIDTH-1:0] stage_data,
    output logic [NREAD*DWIDTH-1:0]   dout,
    output logic                      stall,
    output logic [NSTAGES-1:0]        stage_valid,
    output logic [31:0]               stall_count,
    output logic [31:0]               fwd_count
);

    localparam logic [AWIDTH-1:0] ZERO_ADDR = AWIDTH'(ZERO_REG);
    localparam logic [SW-1:0]     RS_MAX    = SW'(NSTAGES - 1);

    logic [NSTAGES-1:0] valid_reg;
    logic [AWIDTH-1:0]  rc_reg [NSTAGES];
    logic [SW-1:0]      rs_reg [NSTAGES];

    logic [NREAD-1:0]   port_hit;
    logic [NREAD-1:0]   port_rdy;

    logic               issue;
    logic [SW-1:0]      rs_clamped;

    assign stage_valid = valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_port
            logic [AWIDTH-1:0] ra;
            logic              hit;
            logic              rdy;
            logic [DWIDTH-1:0] fwd_data;

            assign ra = ra_addr[gi*AWIDTH +: AWIDTH];

            // Scan oldest to youngest so the youngest match is the one left standing.
            always_comb begin
                hit      = 1'b0;
                rdy      = 1'b0;
                fwd_data = '0;
                for (int i = NSTAGES - 1; i >= 0; i--) begin
                    if (valid_reg[i] && (rc_reg[i] == ra) && (ra != ZERO_ADDR)) begin
                        hit      = 1'b1;
                        rdy      = (NSTAGES == 1) || (i >= int'(rs_reg[i]));
                        fwd_data = stage_data[i*DWIDTH +: DWIDTH];
                    end
                end
            end

            assign port_hit[gi] = hit;
            assign port_rdy[gi] = rdy;
            assign dout[gi*DWIDTH +: DWIDTH] = (hit && rdy) ? fwd_data
                                                             : rf_data[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    assign stall = |(port_hit & ~port_rdy);

    assign issue      = id_valid && !stall && !flush && (id_rc != ZERO_ADDR);
    assign rs_clamped = (int'(id_ready_stage) >= NSTAGES) ? RS_MAX : id_ready_stage;

    // Downstream never stalls: every stage advances each cycle, stage 0 takes a bubble unless issuing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int i = 0; i < NSTAGES; i++) begin
                rc_reg[i] <= '0;
                rs_reg[i] <= '0;
            end
        end else begin
            valid_reg[0] <= issue;
            rc_reg[0]    <= id_rc;
            rs_reg[0]    <= rs_clamped;
            for (int i = 1; i < NSTAGES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                rc_reg[i]    <= rc_reg[i-1];
                rs_reg[i]    <= rs_reg[i-1];
            end
        end
    end

`ifdef BETA_BYPASS_STATS_EN
    logic [31:0] stall_count_reg;
    logic [31:0] fwd_count_reg;
    logic [31:0] fwd_inc;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_inc = '0;
        for (int p = 0; p < NREAD; p++) begin
            fwd_inc = fwd_inc + 32'(port_hit[p] & port_rdy[p]);
        end
        fwd_sum = {1'b0, fwd_count_reg} + {1'b0, fwd_inc};
    end

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
            fwd_count_reg   <= '0;
        end else if (stall) begin
            if (stall_count_reg != 32'hFFFF_FFFF) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end else begin
            fwd_count_reg <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
        end
    end

    assign stall_count = stall_count_reg;
    assign fwd_count   = fwd_count_reg;
`else
    assign stall_count = 32'd0;
    assign fwd_count   = 32'd0;
`endif

endmodule

// File: tb/tb_beta_bypass_pipe.sv
// Directed self-checking bench for beta_bypass_pipe at default parameters
// (DWIDTH=32, NSTAGES=3, NREAD=2, ZERO_REG=31).
module tb_beta_bypass_pipe;

`ifdef BETA_BYPASS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rc;
    logic [1:0]  id_ready_stage;
    logic        flush;
    logic [9:0]  ra_addr;
    logic [63:0] rf_data;
    logic [95:0] stage_data;
    logic [63:0] dout;
    logic        stall;
    logic [2:0]  stage_valid;
    logic [31:0] stall_count;
    logic [31:0] fwd_count;

    logic [4:0]  ra0, ra1;
    logic [31:0] rf0, rf1, sd0, sd1, sd2;

    int n_checks = 0;
    int n_errors = 0;

    assign ra_addr    = {ra1, ra0};
    assign rf_data    = {rf1, rf0};
    assign stage_data = {sd2, sd1, sd0};

    beta_bypass_pipe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rc          (id_rc),
        .id_ready_stage (id_ready_stage),
        .flush          (flush),
        .ra_addr        (ra_addr),
        .rf_data        (rf_data),
        .stage_data     (stage_data),
        .dout           (dout),
        .stall          (stall),
        .stage_valid    (stage_valid),
        .stall_count    (stall_count),
        .fwd_count      (fwd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rc, input logic [1:0] rs);
        id_valid       = 1'b1;
        id_rc          = rc;
        id_ready_stage = rs;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rc = '0; id_ready_stage = '0; flush = 1'b0;
        ra0 = '0; ra1 = '0; rf0 = '0; rf1 = '0; sd0 = '0; sd1 = '0; sd2 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        ra0 = 5'd3; rf0 = 32'h11;
        #1;
        check("rst_dout0", dout[31:0], 64'h11);
        check("rst_stall", stall, 64'd0);
        check("rst_valid", stage_valid, 64'd0);
        check("rst_stallcnt", stall_count, 64'd0);
        check("rst_fwdcnt", fwd_count, 64'd0);

        // ALU result forwarded through every stage
        tick(); issue(5'd3, 2'd0); ra0 = 5'd0;
        #1 check("alu_issue_stall", stall, 64'd0);
        tick(); id_valid = 1'b0; ra0 = 5'd3; sd0 = 32'hAAAA;
        #1 check("alu_s0_dout0", dout[31:0], 64'hAAAA);
        check("alu_s0_stall", stall, 64'd0);
        check("alu_s0_valid", stage_valid, 64'b001);
        tick(); sd0 = '0; sd1 = 32'hBBBB;
        #1 check("alu_s1_dout0", dout[31:0], 64'hBBBB);
        tick(); sd1 = '0; sd2 = 32'hAAAA;
        #1 check("alu_s2_dout0", dout[31:0], 64'hAAAA);
        check("alu_s2_valid", stage_valid, 64'b100);
        tick();
        #1 check("alu_gone_dout0", dout[31:0], 64'h11);
        check("alu_gone_valid", stage_valid, 64'd0);
        check("alu_fwdcnt", fwd_count, STATS ? 64'd3 : 64'd0);

        // Load-use interlock; the consumer's own issue is ignored while stalled
        tick(); ra0 = 5'd0; sd2 = '0; issue(5'd4, 2'd2); ra1 = 5'd0; rf1 = 32'h99;
        #1 check("ld_issue_stall", stall, 64'd0);
        tick(); issue(5'd7, 2'd0); ra1 = 5'd4;
        #1 check("ld_c1_stall", stall, 64'd1);
        check("ld_c1_dout1", dout[63:32], 64'h99);
        check("ld_c1_valid", stage_valid, 64'b001);
        tick();
        #1 check("ld_c2_stall", stall, 64'd1);
        check("ld_c2_valid", stage_valid, 64'b010);
        tick(); sd2 = 32'h55;
        #1 check("ld_c3_stall", stall, 64'd0);
        check("ld_c3_dout1", dout[63:32], 64'h55);
        check("ld_c3_valid", stage_valid, 64'b100);
        check("ld_stallcnt", stall_count, STATS ? 64'd2 : 64'd0);
        check("ld_fwdcnt_pre", fwd_count, STATS ? 64'd3 : 64'd0);
        tick(); id_valid = 1'b0; ra1 = 5'd0; sd2 = '0;
        #1 check("ld_consumer_valid", stage_valid, 64'b001);
        check("ld_fwdcnt_post", fwd_count, STATS ? 64'd4 : 64'd0);
        repeat (3) tick();

        // Youngest match wins on both ports
        issue(5'd5, 2'd0); sd0 = 32'h1; sd1 = 32'h2;
        #1;
        tick(); ra0 = 5'd5; ra1 = 5'd5;
        #1 check("pri_c1_dout0", dout[31:0], 64'h1);
        check("pri_c1_dout1", dout[63:32], 64'h1);
        tick(); id_valid = 1'b0;
        #1 check("pri_c2_dout0", dout[31:0], 64'h1);
        check("pri_c2_dout1", dout[63:32], 64'h1);
        check("pri_c2_valid", stage_valid, 64'b011);
        check("pri_c2_fwdcnt", fwd_count, STATS ? 64'd6 : 64'd0);
        tick(); ra0 = 5'd0; ra1 = 5'd0;
        #1 check("pri_fwdcnt", fwd_count, STATS ? 64'd8 : 64'd0);
        repeat (3) tick();

        // Older ready match must not mask a younger not-ready one
        issue(5'd9, 2'd0);
        #1;
        tick(); issue(5'd9, 2'd2);
        #1 check("mask_issue_stall", stall, 64'd0);
        tick(); id_valid = 1'b0; ra0 = 5'd9; rf0 = 32'h123;
        sd0 = 32'hA0; sd1 = 32'hA1; sd2 = 32'hA2;
        #1 check("mask_c1_stall", stall, 64'd1);
        check("mask_c1_dout0", dout[31:0], 64'h123);
        tick();
        #1 check("mask_c2_stall", stall, 64'd1);
        tick();
        #1 check("mask_c3_stall", stall, 64'd0);
        check("mask_c3_dout0", dout[31:0], 64'hA2);
        check("mask_stallcnt", stall_count, STATS ? 64'd4 : 64'd0);
        check("mask_fwdcnt", fwd_count, STATS ? 64'd8 : 64'd0);
        tick(); ra0 = 5'd0;
        repeat (3) tick();

        // Writes to the zero register are never tracked
        issue(5'd31, 2'd2); sd0 = 32'hDEAD; sd1 = 32'hDEAD; sd2 = 32'hDEAD;
        #1;
        tick(); id_valid = 1'b0; ra0 = 5'd31; rf0 = 32'h0;
        #1 check("zero_dout0", dout[31:0], 64'h0);
        check("zero_stall", stall, 64'd0);
        check("zero_valid", stage_valid, 64'd0);

        // Flushed issue leaves a bubble
        tick(); ra0 = 5'd0; issue(5'd6, 2'd2); flush = 1'b1;
        #1 check("flush_issue_stall", stall, 64'd0);
        tick(); id_valid = 1'b0; flush = 1'b0; ra0 = 5'd6; rf0 = 32'h77;
        #1 check("flush_stall", stall, 64'd0);
        check("flush_dout0", dout[31:0], 64'h77);
        check("flush_valid", stage_valid, 64'd0);

        // Out-of-range ready stage clamps to the last stage
        tick(); ra0 = 5'd0; issue(5'd8, 2'd3);
        #1;
        tick(); id_valid = 1'b0; ra0 = 5'd8; rf0 = 32'h88; sd2 = 32'hC2;
        #1 check("clamp_c1_stall", stall, 64'd1);
        check("clamp_c1_dout0", dout[31:0], 64'h88);
        tick();
        #1 check("clamp_c2_stall", stall, 64'd1);
        tick();
        #1 check("clamp_c3_stall", stall, 64'd0);
        check("clamp_c3_dout0", dout[31:0], 64'hC2);
        check("clamp_stallcnt", stall_count, STATS ? 64'd6 : 64'd0);
        check("clamp_fwdcnt", fwd_count, STATS ? 64'd9 : 64'd0);

        // Asynchronous reset in the middle of a stall
        tick(); ra0 = 5'd0; issue(5'd10, 2'd2);
        #1;
        tick(); id_valid = 1'b0; ra0 = 5'd10; rf0 = 32'h1010;
        #1 check("arst_pre_stall", stall, 64'd1);
        #1 rst_n = 1'b0;
        #1 check("arst_stall", stall, 64'd0);
        check("arst_valid", stage_valid, 64'd0);
        check("arst_dout0", dout[31:0], 64'h1010);
        check("arst_stallcnt", stall_count, 64'd0);
        check("arst_fwdcnt", fwd_count, 64'd0);
        tick(); rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
